demux_seq_16bit_1x4demux: RTL and testbench
===========================================

Name: demux_seq_16bit_1X4DEMUX

Overview:
- Registered 1-to-4 demultiplexer for 16-bit words. It is the distribution counterpart of the 16-bit 4:1 mux.
- One input stream is steered by a 2-bit select (selec_1 = LSB, selec_2 = MSB) into one of four output channels.
- Each output channel has a one-entry holding register with a valid/ready handshake, so a stalled consumer never loses data.
- Each channel also has an accepted-word counter for lab observation.

Parameters:
- WIDTH, 16, data width of the input and of each output channel.
- CNT_W, 8, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- inp_data  input  WIDTH  input word
- inp_valid  input  1  input word present
- inp_ready  output  1  demux can accept the word on this cycle
- selec_1  input  1  channel select LSB
- selec_2  input  1  channel select MSB
- out_y1..out_y4  output  WIDTH each  channel 1..4 data; channel index = {selec_2,selec_1}+1
- out_v1..out_v4  output  1 each  channel data valid
- out_r1..out_r4  input  1 each  channel consumer ready
- cnt_1..cnt_4  output  CNT_W each  words accepted into each channel

Behaviour:
- Reset (rst_n=0 at a rising clk edge): all out_v* = 0, all out_y* = 0, all cnt_* = 0. inp_ready then reflects the empty slots, i.e. it is 1. The reset overrides any transfer on that same edge.
- Channel index: sel = {selec_2, selec_1}. Values 00, 01, 10, 11 select channels 1, 2, 3, 4.
- inp_ready is combinational: ~out_v[sel] | out_r[sel]. It depends only on the selected channel.
- Accept: inp_valid & inp_ready at a clk edge.
  - Loads inp_data into slot[sel] and sets out_v[sel] = 1.
  - Increments cnt[sel] by 1, wrapping modulo 2^CNT_W (255 -> 0).
- Latency: an accepted word appears on out_y[sel] with out_v = 1 on the cycle after the accept edge. There is no combinational data path from input to output.
- Drain: out_v[k] & out_r[k] at an edge clears out_v[k]. out_y[k] holds its last value; it is not cleared.
- Simultaneous drain and accept on the same channel: the slot reloads with the new word and out_v stays 1. This gives full throughput of one word per cycle.
- Accept to channel A with a drain of channel B on the same edge: the two are independent and both take effect.
- Non-selected channels are unaffected by inp_valid and by select changes.
- Select may change every cycle. It is sampled only on the accept edge.
- inp_valid = 0: no slot load, no counter change, even if inp_ready = 1.
- Slot full with out_r = 0: out_y and out_v are held stable (AXI-style rule: data never changes while valid and not ready).
- Reset mid-operation: buffered words are discarded and counters are cleared. No partial state survives.

Decomposition:
- Shared package demux_pkg:
  - WIDTH and CNT_W defaults
  - 2-bit channel index constants CH1 = 2'b00 … CH4 = 2'b11
  - NUM_CH = 4
- Sub-module demux_out_slot, one instance per channel:
  - holds the WIDTH data register, the valid flag and the CNT_W counter
  - inputs: load, drain, d
  - outputs: q, v, cnt, ready_for_load (= ~v | drain)
- The top level contains:
  - the select decode
  - the load-enable generation: load[k] = inp_valid & inp_ready & (sel == k)
  - the inp_ready mux

Test Plan:
1. Reset, then sel = 10, inp_data = 16'hA5A5, inp_valid = 1 for one cycle, all out_r = 1. Next cycle: out_y3 = A5A5, out_v3 = 1, cnt_3 = 1. Other valids stay 0 and other counters stay 0.
2. Back-pressure: out_r1 = 0, send 16'h1111 then 16'h2222 to channel 1. First word accepted. inp_ready drops to 0 and out_y1 holds 1111 while out_r1 = 0. Raise out_r1: 1111 drains on that edge and 2222 is accepted on the same edge, then appears one cycle later.
3. Streaming: all out_r = 1, sel cycles 00, 01, 10, 11, 00… with data 0..7 on back-to-back cycles. inp_ready stays 1 throughout. Each channel receives its words in order with a 1-cycle delay, and every cnt_* = 2.
4. Counter wrap: send 256 words to channel 4 with out_r4 = 1. cnt_4 reads 255 after the 255th word and 0 after the 256th.
5. Reset mid-operation: fill channels 2 and 3 with out_r = 0, then hold rst_n = 0 for one edge. All out_v = 0, all out_y = 0, all cnt = 0, and inp_ready = 1.
6. inp_valid = 0 with selects toggling and all out_r = 1. No out_v ever rises and all counters stay 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 16-bit 1-to-4 demultiplexer:
// default widths, channel count and the 2-bit channel index encoding.
package demux_pkg;

  localparam int WIDTH  = 16;
  localparam int CNT_W  = 8;
  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH1 = 2'b00;
  localparam ch_idx_t CH2 = 2'b01;
  localparam ch_idx_t CH3 = 2'b10;
  localparam ch_idx_t CH4 = 2'b11;

  // selec_2 is the MSB, selec_1 the LSB of the channel index.
  function automatic ch_idx_t ch_sel(input logic s2, input logic s1);
    return {s2, s1};
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: a single-entry holding register with valid flag and a
// wrapping accepted-word counter. Data is held (not cleared) after a drain.
module demux_out_slot #(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int CNT_W = demux_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             v_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ready_for_load_o
);
  import demux_pkg::*;

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A load wins over a drain on the same edge, which gives one word per cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      data_d  = d_i;
      valid_d = 1'b1;
      cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (drain_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_o              = data_q;
  assign v_o              = valid_q;
  assign cnt_o            = cnt_q;
  assign ready_for_load_o = ~valid_q | drain_i;

endmodule

// File: rtl/demux_seq_16bit_1x4demux.sv
// Registered 1-to-4 demultiplexer: the selected channel's slot captures the
// input word on accept; each channel drains through its own valid/ready pair.
module demux_seq_16bit_1x4demux #(
  parameter int WIDTH = demux_pkg::WIDTH,
  parameter int CNT_W = demux_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] inp_data,
  input  logic             inp_valid,
  output logic             inp_ready,
  input  logic             selec_1,
  input  logic             selec_2,
  output logic [WIDTH-1:0] out_y1,
  output logic [WIDTH-1:0] out_y2,
  output logic [WIDTH-1:0] out_y3,
  output logic [WIDTH-1:0] out_y4,
  output logic             out_v1,
  output logic             out_v2,
  output logic             out_v3,
  output logic             out_v4,
  input  logic             out_r1,
  input  logic             out_r2,
  input  logic             out_r3,
  input  logic             out_r4,
  output logic [CNT_W-1:0] cnt_1,
  output logic [CNT_W-1:0] cnt_2,
  output logic [CNT_W-1:0] cnt_3,
  output logic [CNT_W-1:0] cnt_4
);
  import demux_pkg::*;

  ch_idx_t           sel_s;
  logic              inp_ready_s;
  logic [NUM_CH-1:0] out_r_s;
  logic [NUM_CH-1:0] load_s;
  logic [NUM_CH-1:0] v_s;
  logic [NUM_CH-1:0] rfl_s;
  logic [WIDTH-1:0]  y_s   [NUM_CH];
  logic [CNT_W-1:0]  cnt_s [NUM_CH];

  assign sel_s   = ch_sel(selec_2, selec_1);
  assign out_r_s = {out_r4, out_r3, out_r2, out_r1};

  // Ready reflects only the selected channel's slot.
  always_comb begin
    inp_ready_s = 1'b0;
    case (sel_s)
      CH1:     inp_ready_s = rfl_s[0];
      CH2:     inp_ready_s = rfl_s[1];
      CH3:     inp_ready_s = rfl_s[2];
      CH4:     inp_ready_s = rfl_s[3];
      default: inp_ready_s = 1'b0;
    endcase
  end

  always_comb begin
    load_s = {NUM_CH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (inp_valid && inp_ready_s && (sel_s == 2'(k))) begin
        load_s[k] = 1'b1;
      end else begin
        load_s[k] = 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_out_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk              (clk),
      .rst_n            (rst_n),
      .load_i           (load_s[k]),
      .drain_i          (out_r_s[k]),
      .d_i              (inp_data),
      .q_o              (y_s[k]),
      .v_o              (v_s[k]),
      .cnt_o            (cnt_s[k]),
      .ready_for_load_o (rfl_s[k])
    );
  end

  assign inp_ready = inp_ready_s;

  assign out_y1 = y_s[0];
  assign out_y2 = y_s[1];
  assign out_y3 = y_s[2];
  assign out_y4 = y_s[3];

  assign out_v1 = v_s[0];
  assign out_v2 = v_s[1];
  assign out_v3 = v_s[2];
  assign out_v4 = v_s[3];

  assign cnt_1 = cnt_s[0];
  assign cnt_2 = cnt_s[1];
  assign cnt_3 = cnt_s[2];
  assign cnt_4 = cnt_s[3];

endmodule

// File: tb/tb_demux_seq_16bit_1x4demux.sv
// Bench for the registered 1-to-4 demux: a per-channel array model updated on
// each clock, compared against the DUT on every falling edge.
module tb_demux_seq_16bit_1x4demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] inp_data;
  logic        inp_valid;
  logic        inp_ready;
  logic        selec_1, selec_2;
  logic [15:0] out_y1, out_y2, out_y3, out_y4;
  logic        out_v1, out_v2, out_v3, out_v4;
  logic        out_r1, out_r2, out_r3, out_r4;
  logic [7:0]  cnt_1, cnt_2, cnt_3, cnt_4;

  int n_tests = 0;
  int n_fail  = 0;
  bit model_en = 1'b0;

  // Model state: one word, one valid flag and one counter per channel.
  int m_y [4];
  bit m_v [4];
  int m_c [4];

  always #5 clk = ~clk;

  demux_seq_16bit_1x4demux dut (
    .clk(clk), .rst_n(rst_n),
    .inp_data(inp_data), .inp_valid(inp_valid), .inp_ready(inp_ready),
    .selec_1(selec_1), .selec_2(selec_2),
    .out_y1(out_y1), .out_y2(out_y2), .out_y3(out_y3), .out_y4(out_y4),
    .out_v1(out_v1), .out_v2(out_v2), .out_v3(out_v3), .out_v4(out_v4),
    .out_r1(out_r1), .out_r2(out_r2), .out_r3(out_r3), .out_r4(out_r4),
    .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3), .cnt_4(cnt_4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int cur_sel();
    return int'({selec_2, selec_1});
  endfunction

  function automatic bit r_of(input int k);
    bit [3:0] r;
    r = {out_r4, out_r3, out_r2, out_r1};
    return r[k];
  endfunction

  // Reference model: acting on the inputs visible at the rising edge.
  always @(posedge clk) begin
    int  s;
    bit  acc;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_y[k] = 0; m_v[k] = 1'b0; m_c[k] = 0;
      end
    end else begin
      s   = cur_sel();
      acc = inp_valid && (!m_v[s] || r_of(s));
      for (int k = 0; k < 4; k++) begin
        if (r_of(k)) m_v[k] = 1'b0;
      end
      if (acc) begin
        m_y[s] = int'(inp_data);
        m_v[s] = 1'b1;
        m_c[s] = (m_c[s] + 1) % 256;
      end
    end
  end

  // Compare process: every falling edge once the model has been reset.
  always @(negedge clk) begin
    logic [15:0] y [4];
    logic        v [4];
    logic [7:0]  c [4];
    int          s;
    if (model_en) begin
      y = '{out_y1, out_y2, out_y3, out_y4};
      v = '{out_v1, out_v2, out_v3, out_v4};
      c = '{cnt_1, cnt_2, cnt_3, cnt_4};
      for (int k = 0; k < 4; k++) begin
        check($sformatf("out_y%0d", k+1), 32'(y[k]), 32'(m_y[k]));
        check($sformatf("out_v%0d", k+1), 32'(v[k]), 32'(m_v[k]));
        check($sformatf("cnt_%0d",  k+1), 32'(c[k]), 32'(m_c[k]));
      end
      s = cur_sel();
      check("inp_ready", 32'(inp_ready), 32'(!m_v[s] || r_of(s)));
    end
  end

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic cyc(input bit v, input int sel, input logic [15:0] d, input logic [3:0] r);
    inp_valid = v;
    {selec_2, selec_1} = 2'(sel);
    inp_data = d;
    {out_r4, out_r3, out_r2, out_r1} = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 0, 16'h0000, 4'hF);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; inp_data = 16'h0; inp_valid = 1'b0;
    selec_1 = 1'b0; selec_2 = 1'b0;
    {out_r4, out_r3, out_r2, out_r1} = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_en = 1'b1;
    check("reset out_v1", 32'(out_v1), 32'd0);
    check("reset cnt_4", 32'(cnt_4), 32'd0);
    check("reset inp_ready", 32'(inp_ready), 32'd1);
    rst_n = 1'b1;

    // 1: single word to channel 3.
    cyc(1'b1, 2, 16'hA5A5, 4'hF);
    check("t1 out_y3", 32'(out_y3), 32'hA5A5);
    check("t1 out_v3", 32'(out_v3), 32'd1);
    check("t1 cnt_3", 32'(cnt_3), 32'd1);
    check("t1 other v", 32'({out_v1, out_v2, out_v4}), 32'd0);
    check("t1 other cnt", 32'(cnt_1) + 32'(cnt_2) + 32'(cnt_4), 32'd0);

    // 2: back-pressure on channel 1.
    cyc(1'b1, 0, 16'h1111, 4'hE);
    inp_data = 16'h2222; #1;
    check("t2 inp_ready low", 32'(inp_ready), 32'd0);
    cyc(1'b1, 0, 16'h2222, 4'hE);
    check("t2 hold y1", 32'(out_y1), 32'h1111);
    check("t2 hold v1", 32'(out_v1), 32'd1);
    cyc(1'b1, 0, 16'h2222, 4'hF);
    check("t2 reload y1", 32'(out_y1), 32'h2222);
    check("t2 reload v1", 32'(out_v1), 32'd1);
    check("t2 cnt_1", 32'(cnt_1), 32'd2);
    cyc(1'b0, 0, 16'h0000, 4'hF);
    check("t2 drained v1", 32'(out_v1), 32'd0);
    check("t2 y1 kept", 32'(out_y1), 32'h2222);

    // 3: streaming round-robin, data 0..7.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, i % 4, 16'(i), 4'hF);
      check("t3 y in order", 32'({out_y4, out_y3, out_y2, out_y1} >> (16 * (i % 4))) & 32'hFFFF, 32'(i));
    end
    check("t3 cnt sum", 32'(cnt_1 == 8'd2 && cnt_2 == 8'd2 && cnt_3 == 8'd2 && cnt_4 == 8'd2), 32'd1);

    // 4: counter wrap on channel 4.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, 3, 16'($urandom), 4'hF);
      if (i == 254) check("t4 cnt_4 at 255", 32'(cnt_4), 32'd255);
    end
    check("t4 cnt_4 wrap", 32'(cnt_4), 32'd0);
    cyc(1'b0, 3, 16'h0000, 4'hF);

    // 5: reset with channels 2 and 3 holding words.
    do_reset();
    cyc(1'b1, 1, 16'hBEEF, 4'h0);
    cyc(1'b1, 2, 16'hCAFE, 4'h0);
    check("t5 filled", 32'({out_v2, out_v3}), 32'd3);
    rst_n = 1'b0;
    cyc(1'b1, 1, 16'h1234, 4'h0);
    rst_n = 1'b1;
    check("t5 v all", 32'({out_v1, out_v2, out_v3, out_v4}), 32'd0);
    check("t5 y2", 32'(out_y2), 32'd0);
    check("t5 y3", 32'(out_y3), 32'd0);
    check("t5 cnt", 32'(cnt_2) + 32'(cnt_3), 32'd0);
    check("t5 inp_ready", 32'(inp_ready), 32'd1);

    // 6: no valid, toggling selects.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, int'($urandom_range(0, 3)), 16'($urandom), 4'hF);
      check("t6 no valid", 32'({out_v1, out_v2, out_v3, out_v4}), 32'd0);
    end
    check("t6 cnt", 32'(cnt_1) + 32'(cnt_2) + 32'(cnt_3) + 32'(cnt_4), 32'd0);

    // Randomized traffic with random back-pressure and occasional reset.
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cyc(1'($urandom), int'($urandom_range(0, 3)), 16'($urandom), 4'($urandom));
    end
    rst_n = 1'b1;
    cyc(1'b0, 0, 16'h0000, 4'hF);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
